isp_raw_tpg: RTL and testbench

// - Bayer raw test-pattern source; drives the href/vsync/raw stream that ISP stages (isp_bnr and later) consume.
// - Generates the full frame timing: vsync, back porch, active lines with horizontal blanking, and front porch.
// - Active pixels carry a selectable Bayer-mosaiced pattern.
// - Sits in place of the sensor capture front end for bring-up and regression.

---
 rtl/isp_raw_tpg.sv | 102 ++++++++++
 tb/tb_isp_raw_tpg.sv | 125 ++++++++++++
 2 files changed

// File: rtl/isp_raw_tpg.sv
// isp_raw_tpg: Bayer raw test-pattern source with full frame timing; define ISP_TPG_ANIM_EN to animate patterns per frame
module isp_raw_tpg #(
  parameter int BITS        = 8,
  parameter int WIDTH       = 1280,
  parameter int HEIGHT      = 960,
  parameter int BAYER       = 3,
  parameter int HBLANK      = 64,
  parameter int VSYNC_LINES = 2,
  parameter int VBP_LINES   = 4,
  parameter int VFP_LINES   = 4
) (
  input  logic            pclk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic [1:0]      pattern,
  output logic            out_href,
  output logic            out_vsync,
  output logic [BITS-1:0] out_raw,
  output logic            frame_done
);
  localparam int LINE = WIDTH + HBLANK;
  localparam int XW = $clog2(LINE);
  localparam int YW = $clog2(HEIGHT + VSYNC_LINES + VBP_LINES + VFP_LINES + 1);
  localparam int unsigned BW = (WIDTH / 8 < 1) ? 1 : WIDTH / 8;
  localparam logic [BITS-1:0] MAX = '1;
  localparam logic [2:0] IDLE = 3'd0, VSYNC = 3'd1, VBP = 3'd2, ACTIVE = 3'd3, VFP = 3'd4;
  logic [2:0] state, nxt;
  logic [XW-1:0] x;
  logic [YW-1:0] y, lines;
  logic [1:0] pat, fmt;
  logic [15:0] lfsr, lfsr_nxt;
  logic x_last, y_last, frame_end, start, href_c, lit;
  logic [2:0] bar;
  int unsigned bq;
  logic [BITS-1:0] pix;
`ifdef ISP_TPG_ANIM_EN
  logic [7:0] frame;
  // frame counter drives the per-frame animation offset
  always_ff @(posedge pclk)
    if (!rst_n) frame <= 8'd0;
    else if (frame_end) frame <= frame + 8'd1;
`else
  localparam logic [7:0] frame = 8'd0;
`endif
  // line/state bookkeeping and colour/pattern selection for the current cycle
  always_comb begin
    lines = state == VSYNC ? YW'(VSYNC_LINES) : state == VBP ? YW'(VBP_LINES) :
            state == ACTIVE ? YW'(HEIGHT) : YW'(VFP_LINES);
    x_last = x == XW'(LINE - 1);
    y_last = y == lines - YW'(1);
    frame_end = state == VFP && x_last && y_last;
    start = enable && (state == IDLE || frame_end);
    href_c = state == ACTIVE && x < XW'(WIDTH);
    nxt = state == VSYNC ? VBP : state == VBP ? ACTIVE : state == ACTIVE ? VFP : (enable ? VSYNC : IDLE);
    lfsr_nxt = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    fmt = 2'(BAYER) ^ {y[0], x[0]};
    bq = 32'(x) / BW;
    bar = (bq > 7 ? 3'd7 : 3'(bq)) + frame[2:0];
    lit = fmt == 2'd0 ? !bar[1] : fmt == 2'd3 ? !bar[0] : !bar[2];
    pix = pat == 2'd0 ? {BITS{lit}} :
          pat == 2'd1 ? BITS'(x) + BITS'(frame) :
          pat == 2'd2 ? (fmt == 2'd0 ? MAX >> 1 : fmt == 2'd3 ? MAX >> 3 : MAX >> 2) :
          lfsr_nxt[BITS-1:0];
  end
  // frame FSM with pixel/line counters that wrap only at line and state boundaries
  always_ff @(posedge pclk)
    if (!rst_n) begin
      state <= IDLE;
      x <= '0;
      y <= '0;
    end else if (state == IDLE) begin
      if (enable) state <= VSYNC;
    end else begin
      x <= x_last ? '0 : x + XW'(1);
      if (x_last) begin
        y <= y_last ? '0 : y + YW'(1);
        if (y_last) state <= nxt;
      end
    end
  // pattern is frozen for the whole frame; LFSR reseeds at frame start and steps per active pixel
  always_ff @(posedge pclk)
    if (!rst_n) begin
      pat <= 2'd0;
      lfsr <= 16'hACE1;
    end else if (start) begin
      pat <= pattern;
      lfsr <= 16'hACE1 ^ {8'd0, frame};
    end else if (href_c) lfsr <= lfsr_nxt;
  // registered outputs, all delayed equally so relative timing is preserved
  always_ff @(posedge pclk)
    if (!rst_n) begin
      out_href <= 1'b0;
      out_vsync <= 1'b0;
      out_raw <= '0;
      frame_done <= 1'b0;
    end else begin
      out_href <= href_c;
      out_vsync <= state == VSYNC;
      out_raw <= href_c ? pix : '0;
      frame_done <= frame_end;
    end
endmodule

// File: tb/tb_isp_raw_tpg.sv
// tb_isp_raw_tpg: directed checks of frame timing, flat/PRBS/bar patterns, enable drop and mid-line reset
module tb_isp_raw_tpg;
  logic clk = 1'b0, rst_n, en_a, en_b;
  logic [1:0] pat_a;
  logic hr_a, vs_a, fd_a, hr_b, vs_b, fd_b;
  logic [7:0] raw_a, raw_b;
  int checks = 0, errors = 0, cyc = 0, fidx = 0, pn = 0, bn = 0, blank_bad = 0;
  int vs_rise[$], vs_fall[$], hr_rise[$], hr_fall[$], fd_q[$];
  logic [7:0] fpix [0:7][0:31];
  logic [7:0] bpix [0:15];
  logic pv = 1'b0, ph = 1'b0;

  always #5 clk = ~clk;

  isp_raw_tpg #(.BITS(8), .WIDTH(8), .HEIGHT(4), .BAYER(3), .HBLANK(4),
                .VSYNC_LINES(1), .VBP_LINES(1), .VFP_LINES(1)) dut_a (
    .pclk(clk), .rst_n(rst_n), .enable(en_a), .pattern(pat_a),
    .out_href(hr_a), .out_vsync(vs_a), .out_raw(raw_a), .frame_done(fd_a));

  isp_raw_tpg #(.BITS(8), .WIDTH(16), .HEIGHT(2), .BAYER(0), .HBLANK(4),
                .VSYNC_LINES(1), .VBP_LINES(1), .VFP_LINES(1)) dut_b (
    .pclk(clk), .rst_n(rst_n), .enable(en_b), .pattern(2'd0),
    .out_href(hr_b), .out_vsync(vs_b), .out_raw(raw_b), .frame_done(fd_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (vs_a === 1'b1 && !pv) begin vs_rise.push_back(cyc); fidx++; pn = 0; end
    if (vs_a === 1'b0 && pv) vs_fall.push_back(cyc);
    if (hr_a === 1'b1 && !ph) hr_rise.push_back(cyc);
    if (hr_a === 1'b0 && ph) hr_fall.push_back(cyc);
    if (fd_a === 1'b1) fd_q.push_back(cyc);
    if (hr_a === 1'b1 && fidx > 0 && fidx <= 8 && pn < 32) begin fpix[fidx-1][pn] = raw_a; pn++; end
    if (hr_a === 1'b0 && raw_a !== 8'd0 && rst_n === 1'b1) blank_bad++;
    if (hr_b === 1'b1 && bn < 16) begin bpix[bn] = raw_b; bn++; end
    pv = vs_a === 1'b1;
    ph = hr_a === 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; pat_a = 2'd2;
    repeat (3) @(negedge clk);
    chk("rst_href", hr_a, 0);
    chk("rst_vsync", vs_a, 0);
    chk("rst_raw", raw_a, 0);
    chk("rst_frame_done", fd_a, 0);
    rst_n = 1'b1; en_a = 1'b1; en_b = 1'b1;
    for (int i = 0; i < 400 && vs_rise.size() < 1; i++) @(negedge clk);
    repeat (30) @(negedge clk);
    pat_a = 2'd3;
    for (int i = 0; i < 600 && vs_rise.size() < 4; i++) @(negedge clk);
    chk("frame3_started", vs_rise.size(), 4);
    repeat (40) @(negedge clk);
    en_a = 1'b0;
    for (int i = 0; i < 400 && fd_q.size() < 4; i++) @(negedge clk);
    repeat (50) @(negedge clk);
    chk("drop_fd_count", fd_q.size(), 4);
    chk("drop_no_new_vsync", vs_rise.size(), 4);
    chk("drop_href_lines", hr_rise.size(), 16);
    chk("idle_href", hr_a, 0);
    chk("idle_vsync", vs_a, 0);
    chk("idle_raw", raw_a, 0);
    chk("vsync_width", vs_fall[0] - vs_rise[0], 12);
    chk("first_href_delay", hr_rise[0] - vs_rise[0], 24);
    chk("href_width", hr_fall[0] - hr_rise[0], 8);
    n = 0;
    foreach (hr_rise[i]) if (hr_rise[i] > vs_rise[0] && hr_rise[i] < vs_rise[1]) n++;
    chk("lines_per_frame", n, 4);
    chk("frame_period", fd_q[1] - fd_q[0], 84);
    chk("fd_before_vsync", vs_rise[1] - fd_q[0], 1);
    chk("flat_r0c0", fpix[0][0], 31);
    chk("flat_r0c1", fpix[0][1], 63);
    chk("flat_r0c2", fpix[0][2], 31);
    chk("flat_r0c3", fpix[0][3], 63);
    chk("flat_r1c0", fpix[0][8], 63);
    chk("flat_r1c1", fpix[0][9], 127);
    chk("blank_raw_zero", blank_bad, 0);
    chk("prbs_f1_p0", fpix[1][0], 8'h70);
    chk("prbs_f1_p1", fpix[1][1], 8'h38);
    chk("prbs_f1_p2", fpix[1][2], 8'h9C);
    chk("prbs_f2_p0", fpix[2][0], 8'h70);
    chk("prbs_f2_p1", fpix[2][1], 8'h38);
    chk("prbs_f2_p2", fpix[2][2], 8'h9C);
    chk("bars_c0", bpix[0], 255);
    chk("bars_c1", bpix[1], 255);
    chk("bars_c10", bpix[10], 255);
    chk("bars_c11", bpix[11], 0);
    chk("bars_c14", bpix[14], 0);
    chk("bars_c15", bpix[15], 0);
    en_a = 1'b1;
    for (int i = 0; i < 400 && vs_rise.size() < 5; i++) @(negedge clk);
    for (int i = 0; i < 400 && hr_rise.size() < 17; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("midline_href_before", hr_a, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_href", hr_a, 0);
    chk("midrst_vsync", vs_a, 0);
    chk("midrst_raw", raw_a, 0);
    chk("midrst_fd", fd_a, 0);
    en_a = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("midrst_stays_idle", vs_rise.size(), 5);
    chk("midrst_no_partial_fd", fd_q.size(), 4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
